// File: rtl/dup_mask_sched.sv
// dup_mask_sched: round-robin scheduler that pushes per-requester duplicate
// masks into the downstream mask FIFO. It tracks in-flight masks with a credit
// counter and stops granting once the FIFO is full or while a flush is pending.
// Optional build macro: DUP_SCHED_MASK_CHECK_EN. When it is defined, granted
// masks are checked for out-of-range or chained origins, and a bad mask sets err.
module dup_mask_sched #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned NUM_ELEMENTS   = 8,
  parameter int unsigned MAX_IN_TRANSIT = 16,
  localparam int unsigned IDX_W = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1,
  localparam int unsigned REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CNT_W = $clog2(MAX_IN_TRANSIT + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ*NUM_ELEMENTS-1:0]       req_duplicates,
  input  logic [NUM_REQ*NUM_ELEMENTS*IDX_W-1:0] req_origins,
  output logic                                  mask_valid,
  output logic [NUM_ELEMENTS-1:0]               mask_duplicates,
  output logic [NUM_ELEMENTS*IDX_W-1:0]         mask_origins,
  output logic [REQ_W-1:0]                      mask_src,
  input  logic                                  beat_consumed,
  input  logic                                  flush,
  output logic [CNT_W-1:0]                      credits_used,
  output logic                                  idle,
  output logic                                  err
);

  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_IN_TRANSIT);
  localparam logic [REQ_W-1:0] LAST_REQ = REQ_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                        state;
  state_t                        state_next;
  logic [REQ_W-1:0]              last_grant;
  logic [REQ_W-1:0]              scan_idx;
  logic [REQ_W-1:0]              grant_idx;
  logic                          found;
  logic                          grant_ok;
  logic                          xfer;
  logic                          underflow;
  logic                          mask_bad;
  logic [CNT_W-1:0]              credits_next;
  logic [NUM_ELEMENTS-1:0]       sel_dup;
  logic [NUM_ELEMENTS*IDX_W-1:0] sel_org;
  logic [NUM_ELEMENTS-1:0]       dup_arr [NUM_REQ];
  logic [NUM_ELEMENTS*IDX_W-1:0] org_arr [NUM_REQ];

  // Split the flat request buses into one mask per requester
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign dup_arr[r] = req_duplicates[r*NUM_ELEMENTS +: NUM_ELEMENTS];
    assign org_arr[r] = req_origins[r*NUM_ELEMENTS*IDX_W +: NUM_ELEMENTS*IDX_W];
  end

  // Grants are allowed only in IDLE/RUN, with headroom, no flush and out of reset.
  // A same-cycle beat_consumed deliberately does not create headroom.
  assign grant_ok = !rst && !flush && (credits_used < MAX_C) &&
                    ((state == IDLE) || (state == RUN));

  // Round-robin search that starts one past the last granted requester
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan_idx  = (last_grant == LAST_REQ) ? '0 : last_grant + REQ_W'(1);
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
      scan_idx = (scan_idx == LAST_REQ) ? '0 : scan_idx + REQ_W'(1);
    end
  end

  assign xfer = grant_ok & found;

  // One-hot ready toward the winning requester
  always_comb begin
    req_ready = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      req_ready[r] = xfer && (grant_idx == REQ_W'(r));
    end
  end

  assign sel_dup = dup_arr[grant_idx];
  assign sel_org = org_arr[grant_idx];

`ifdef DUP_SCHED_MASK_CHECK_EN
  logic [IDX_W-1:0] lane_org;

  // Flag duplicate lanes whose origin is out of range or is itself a duplicate
  always_comb begin
    mask_bad = 1'b0;
    lane_org = '0;
    for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
      lane_org = sel_org[i*IDX_W +: IDX_W];
      if (sel_dup[i]) begin
        if (32'(lane_org) >= NUM_ELEMENTS) begin
          mask_bad = 1'b1;
        end else if (sel_dup[lane_org]) begin
          mask_bad = 1'b1;
        end
      end
    end
  end
`else
  assign mask_bad = 1'b0;
`endif

  // Credit update: a transfer adds one, a consumed beat frees one, both cancel.
  // A consume with no credits outstanding is an underflow and the count stays at 0.
  always_comb begin
    credits_next = credits_used;
    underflow    = 1'b0;
    if (xfer && !beat_consumed) begin
      credits_next = credits_used + CNT_W'(1);
    end else if (!xfer && beat_consumed) begin
      if (credits_used == '0) begin
        underflow = 1'b1;
      end else begin
        credits_next = credits_used - CNT_W'(1);
      end
    end
  end

  // Next-state logic, where a flush with outstanding credits overrides everything
  always_comb begin
    state_next = state;
    if (flush && (credits_next != '0)) begin
      state_next = DRAIN;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) state_next = RUN;
        end
        RUN: begin
          if (credits_next == MAX_C) begin
            state_next = FULL;
          end else if (credits_next == '0) begin
            state_next = IDLE;
          end
        end
        FULL: begin
          if (credits_next < MAX_C) state_next = RUN;
        end
        DRAIN: begin
          if ((credits_next == '0) && !flush) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register and the registered idle indication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idle  <= 1'b1;
    end else begin
      state <= state_next;
      idle  <= (state_next == IDLE);
    end
  end

  // Credit counter, sticky error flag and arbitration pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_used <= '0;
      err          <= 1'b0;
      last_grant   <= LAST_REQ;
    end else begin
      credits_used <= credits_next;
      err          <= err | underflow | (xfer & mask_bad);
      if (xfer) last_grant <= grant_idx;
    end
  end

  // Registered push of the granted mask into the downstream FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_valid      <= 1'b0;
      mask_src        <= '0;
      mask_duplicates <= '0;
      mask_origins    <= '0;
    end else begin
      mask_valid <= xfer;
      if (xfer) begin
        mask_src        <= grant_idx;
        mask_duplicates <= sel_dup;
        mask_origins    <= sel_org;
      end
    end
  end

endmodule

// File: tb/tb_dup_mask_sched.sv
// Testbench for dup_mask_sched. A behavioural model predicts grants, credits,
// idle and err on every cycle. Each expected mask push goes into a queue, and a
// separate monitor checks those pushes against the DUT output stream.
module tb_dup_mask_sched;
  localparam int NR   = 4;
  localparam int NE   = 4;
  localparam int MAXT = 8;
  localparam int IW   = 2;
  localparam int RW   = 2;
  localparam int CW   = 4;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_FULL  = 2;
  localparam int S_DRAIN = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NR-1:0]        req_valid = '0;
  logic [NR-1:0]        req_ready;
  logic [NR*NE-1:0]     req_duplicates = '0;
  logic [NR*NE*IW-1:0]  req_origins = '0;
  logic                 mask_valid;
  logic [NE-1:0]        mask_duplicates;
  logic [NE*IW-1:0]     mask_origins;
  logic [RW-1:0]        mask_src;
  logic                 beat_consumed = 1'b0;
  logic                 flush = 1'b0;
  logic [CW-1:0]        credits_used;
  logic                 idle;
  logic                 err;

  typedef struct {
    int               due;
    logic [NE-1:0]    dup;
    logic [NE*IW-1:0] org;
    logic [RW-1:0]    src;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_credits;
  int   m_last;
  int   m_st;
  logic m_err;
  logic err_exp;

  dup_mask_sched #(
    .NUM_REQ(NR),
    .NUM_ELEMENTS(NE),
    .MAX_IN_TRANSIT(MAXT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_duplicates(req_duplicates),
    .req_origins(req_origins),
    .mask_valid(mask_valid),
    .mask_duplicates(mask_duplicates),
    .mask_origins(mask_origins),
    .mask_src(mask_src),
    .beat_consumed(beat_consumed),
    .flush(flush),
    .credits_used(credits_used),
    .idle(idle),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every pushed expectation must appear exactly on its due cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        mon_e = q.pop_front();
        chk("mask_valid", 64'(mask_valid), 64'd1);
        chk("mask_duplicates", 64'(mask_duplicates), 64'(mon_e.dup));
        chk("mask_origins", 64'(mask_origins), 64'(mon_e.org));
        chk("mask_src", 64'(mask_src), 64'(mon_e.src));
      end else begin
        chk("mask_valid_low", 64'(mask_valid), 64'd0);
      end
    end
  end

  // Reference model step, run once per cycle while the inputs are stable
  task automatic model_eval();
    logic          allowed;
    logic          found;
    logic          xfer;
    int            win;
    int            r;
    int            nc;
    int            ns;
    int            o;
    logic [NR-1:0] er;
    exp_t          e;
    logic [NE-1:0] sdup;
    logic [NE*IW-1:0] sorg;

    allowed = ((m_st == S_IDLE) || (m_st == S_RUN)) && (m_credits < MAXT) && !flush;
    found = 1'b0;
    win = 0;
    for (int k = 1; k <= NR; k++) begin
      r = (m_last + k) % NR;
      if (!found && req_valid[r]) begin
        found = 1'b1;
        win = r;
      end
    end
    xfer = allowed && found;
    er = '0;
    if (xfer) er[win] = 1'b1;

    chk("req_ready", 64'(req_ready), 64'(er));
    chk("credits_used", 64'(credits_used), 64'(m_credits));
    chk("idle", 64'(idle), 64'(m_st == S_IDLE));
    chk("err", 64'(err), 64'(m_err));

    if (xfer) begin
      sdup = req_duplicates[win*NE +: NE];
      sorg = req_origins[win*NE*IW +: NE*IW];
      e.due = cyc + 1;
      e.dup = sdup;
      e.org = sorg;
      e.src = RW'(win);
      q.push_back(e);
      m_last = win;
`ifdef DUP_SCHED_MASK_CHECK_EN
      for (int i = 0; i < NE; i++) begin
        o = int'(sorg[i*IW +: IW]);
        if (sdup[i] && ((o >= NE) || sdup[o])) m_err = 1'b1;
      end
`else
      o = 0;
`endif
    end

    nc = m_credits + (xfer ? 1 : 0) - (beat_consumed ? 1 : 0);
    if (nc < 0) begin
      m_err = 1'b1;
      nc = 0;
    end

    if (flush && nc > 0) begin
      ns = S_DRAIN;
    end else begin
      ns = m_st;
      case (m_st)
        S_IDLE:  if (xfer) ns = S_RUN;
        S_RUN:   if (nc == MAXT) ns = S_FULL; else if (nc == 0) ns = S_IDLE;
        S_FULL:  if (nc < MAXT) ns = S_RUN;
        default: if (nc == 0 && !flush) ns = S_IDLE;
      endcase
    end
    m_credits = nc;
    m_st = ns;
  endtask

  task automatic step(input logic [NR-1:0] v, input logic c, input logic f,
                      input logic [NR*NE-1:0] dup, input logic [NR*NE*IW-1:0] org);
    @(posedge clk);
    #1;
    req_valid      = v;
    beat_consumed  = c;
    flush          = f;
    req_duplicates = dup;
    req_origins    = org;
    @(negedge clk);
    model_eval();
  endtask

  task automatic rstep(input logic [NR-1:0] v, input logic c, input logic f);
    step(v, c, f, (NR*NE)'($urandom), (NR*NE*IW)'($urandom));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = '1;
    beat_consumed = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mask_valid", 64'(mask_valid), 64'd0);
    chk("rst_mask_src", 64'(mask_src), 64'd0);
    chk("rst_credits", 64'(credits_used), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = '0;
    q.delete();
    m_credits = 0;
    m_last = NR - 1;
    m_st = S_IDLE;
    m_err = 1'b0;
  endtask

  initial begin
    int flush_run;
    logic c;

    do_reset();

    // All requesters valid: grants rotate 0,1,2,3,0,1,2,3 until the FIFO is full
    repeat (8) rstep(4'hF, 1'b0, 1'b0);
    rstep(4'hF, 1'b0, 1'b0);
    chk("burst_credits", 64'(credits_used), 64'd8);
    chk("full_no_ready", 64'(req_ready), 64'd0);

    // A single consume while full frees one slot, and the grant resumes a cycle later
    rstep(4'h1, 1'b1, 1'b0);
    chk("full_consume_no_bypass", 64'(req_ready), 64'd0);
    rstep(4'h1, 1'b0, 1'b0);
    chk("resume_ready", 64'(req_ready), 64'd1);
    rstep(4'h0, 1'b0, 1'b0);
    chk("refill_credits", 64'(credits_used), 64'd8);

    // Drain down to 3 credits, then a transfer and a consume in the same cycle
    repeat (5) rstep(4'h0, 1'b1, 1'b0);
    rstep(4'hF, 1'b1, 1'b0);
    rstep(4'h0, 1'b0, 1'b0);
    chk("cancel_credits", 64'(credits_used), 64'd3);

    // Flush with 2 credits outstanding: no grants until drained and released
    rstep(4'h0, 1'b1, 1'b0);
    rstep(4'hF, 1'b0, 1'b1);
    chk("flush_no_ready", 64'(req_ready), 64'd0);
    rstep(4'hF, 1'b1, 1'b1);
    rstep(4'hF, 1'b1, 1'b1);
    rstep(4'hF, 1'b0, 1'b1);
    chk("drain_credits", 64'(credits_used), 64'd0);
    chk("drain_not_idle", 64'(idle), 64'd0);
    rstep(4'h0, 1'b0, 1'b0);
    rstep(4'h0, 1'b0, 1'b0);
    chk("drain_to_idle", 64'(idle), 64'd1);

    // Randomized traffic with occasional flush windows, never underflowing
    flush_run = 0;
    for (int n = 0; n < 400; n++) begin
      if (flush_run > 0) flush_run--;
      else if ($urandom_range(0, 39) == 0) flush_run = $urandom_range(3, 12);
      c = (m_credits > 0) && ($urandom_range(0, 2) != 0);
      rstep(NR'($urandom), c, flush_run > 0);
    end

    // Reset in the middle of traffic discards all in-flight accounting
    repeat (3) rstep(4'hF, 1'b0, 1'b0);
    do_reset();
    rstep(4'h0, 1'b0, 1'b0);

    // Chained duplicate mask: lane2 points at lane1, which is itself a duplicate
    do_reset();
    step(4'h1, 1'b0, 1'b0, 16'h0006, 32'h0000_0010);
    rstep(4'h0, 1'b0, 1'b0);
`ifdef DUP_SCHED_MASK_CHECK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    chk("mask_check_err", 64'(err), 64'(err_exp));
    rstep(4'h0, 1'b1, 1'b0);

    // Underflow sets a sticky error and the count stays at zero
    do_reset();
    rstep(4'h0, 1'b1, 1'b0);
    rstep(4'h0, 1'b0, 1'b0);
    chk("underflow_err", 64'(err), 64'd1);
    chk("underflow_credits", 64'(credits_used), 64'd0);
    repeat (3) rstep(4'h3, 1'b0, 1'b0);
    chk("underflow_sticky", 64'(err), 64'd1);
    rstep(4'h0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
